// File: rtl/game_screen_ctl.sv
// Penalty game sequencer: match FSM, score keeping, frame-aligned screen select
// and shared image ROM address arbitration. Optional: AUTO_RESTART_EN.
module game_screen_ctl #(
  parameter int ROUNDS          = 5,
  parameter int END_HOLD_FRAMES = 180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        left_click,
  input  logic        role_first,
  input  logic        result_valid,
  input  logic        result_goal,
  input  logic [19:0] start_addr,
  input  logic [19:0] shooter_addr,
  input  logic [19:0] keeper_addr,
  input  logic [19:0] end_addr,
  output logic [19:0] rom_addr,
  output logic [2:0]  screen_sel,
  output logic [3:0]  player_score,
  output logic [3:0]  opp_score,
  output logic [4:0]  shot_cnt
);

  typedef enum logic [2:0] {
    S_START   = 3'd0,
    S_SHOOTER = 3'd1,
    S_KEEPER  = 3'd2,
    S_WIN     = 3'd3,
    S_LOSE    = 3'd4
  } state_t;

  localparam logic [4:0] REG_SHOTS = 5'(2 * ROUNDS);
  localparam logic [4:0] MAX_SHOTS = 5'd30;

  state_t      state, state_nx;
  logic        click_q, vblnk_q;
  logic        click_rise, frame_tick;
  logic [3:0]  p_nx, o_nx, p_inc, o_inc;
  logic [4:0]  n_nx, n_inc;

`ifdef AUTO_RESTART_EN
  localparam logic [7:0] HOLD = 8'(END_HOLD_FRAMES);
  logic [7:0] hold_cnt, hold_nx;
`endif

  assign click_rise = left_click & ~click_q;
  assign frame_tick = vblnk & ~vblnk_q;

  always_comb begin
    state_nx = state;
    p_nx     = player_score;
    o_nx     = opp_score;
    n_nx     = shot_cnt;
`ifdef AUTO_RESTART_EN
    hold_nx  = hold_cnt;
`endif
    n_inc = shot_cnt + 5'd1;
    p_inc = player_score;
    o_inc = opp_score;
    if (result_goal && state == S_SHOOTER && player_score != 4'hf)
      p_inc = player_score + 4'd1;
    if (result_goal && state == S_KEEPER && opp_score != 4'hf)
      o_inc = opp_score + 4'd1;

    case (state)
      S_START: begin
        if (click_rise) begin
          p_nx     = 4'd0;
          o_nx     = 4'd0;
          n_nx     = 5'd0;
          state_nx = role_first ? S_KEEPER : S_SHOOTER;
        end
      end
      S_SHOOTER, S_KEEPER: begin
        if (result_valid) begin
          p_nx = p_inc;
          o_nx = o_inc;
          n_nx = n_inc;
          if (n_inc >= REG_SHOTS && !n_inc[0] && p_inc != o_inc)
            state_nx = (p_inc > o_inc) ? S_WIN : S_LOSE;
          else if (n_inc == MAX_SHOTS)
            state_nx = S_LOSE;
          else
            state_nx = (state == S_SHOOTER) ? S_KEEPER : S_SHOOTER;
`ifdef AUTO_RESTART_EN
          hold_nx = 8'd0;
`endif
        end
      end
      S_WIN, S_LOSE: begin
        if (click_rise) begin
          state_nx = S_START;
        end
`ifdef AUTO_RESTART_EN
        else if (frame_tick) begin
          hold_nx = hold_cnt + 8'd1;
          if (hold_nx == HOLD)
            state_nx = S_START;
        end
`endif
      end
      default: state_nx = S_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_START;
      click_q      <= 1'b0;
      vblnk_q      <= 1'b0;
      player_score <= 4'd0;
      opp_score    <= 4'd0;
      shot_cnt     <= 5'd0;
      screen_sel   <= 3'd0;
      rom_addr     <= 20'd0;
`ifdef AUTO_RESTART_EN
      hold_cnt     <= 8'd0;
`endif
    end else begin
      state        <= state_nx;
      click_q      <= left_click;
      vblnk_q      <= vblnk;
      player_score <= p_nx;
      opp_score    <= o_nx;
      shot_cnt     <= n_nx;
`ifdef AUTO_RESTART_EN
      hold_cnt     <= hold_nx;
`endif
      // only the state sampled at the frame edge reaches the screen
      if (frame_tick)
        screen_sel <= state;
      case (screen_sel)
        3'd0:       rom_addr <= start_addr;
        3'd1:       rom_addr <= shooter_addr;
        3'd2:       rom_addr <= keeper_addr;
        3'd3, 3'd4: rom_addr <= end_addr;
        default:    rom_addr <= 20'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_game_screen_ctl.sv
// Randomised bench for game_screen_ctl against a behavioural match model.
// Honours AUTO_RESTART_EN the same way as the design.
module tb_game_screen_ctl;

  localparam int R    = 5;
  localparam int HOLD = 3;

  logic        clk = 0;
  logic        rst;
  logic        vblnk = 0;
  logic        left_click, role_first;
  logic        result_valid, result_goal;
  logic [19:0] start_addr, shooter_addr, keeper_addr, end_addr;
  logic [19:0] rom_addr;
  logic [2:0]  screen_sel;
  logic [3:0]  player_score, opp_score;
  logic [4:0]  shot_cnt;

  int checks = 0;
  int errors = 0;

  game_screen_ctl #(.ROUNDS(R), .END_HOLD_FRAMES(HOLD)) dut (
    .clk(clk), .rst(rst), .vblnk(vblnk), .left_click(left_click),
    .role_first(role_first), .result_valid(result_valid),
    .result_goal(result_goal), .start_addr(start_addr),
    .shooter_addr(shooter_addr), .keeper_addr(keeper_addr),
    .end_addr(end_addr), .rom_addr(rom_addr), .screen_sel(screen_sel),
    .player_score(player_score), .opp_score(opp_score),
    .shot_cnt(shot_cnt)
  );

  always #5 clk = ~clk;

  // 12-cycle frames, blank for the last 3
  initial begin
    forever begin
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        vblnk = (i >= 9);
      end
    end
  end

  // model: game phase 0 start,1 shoot,2 keep,3 win,4 lose
  int          m_st, m_sel, m_p, m_o, m_n, m_fc;
  logic [19:0] m_addr;
  logic        m_cq, m_vq;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit cr, ft;
    int nst;
    if (rst) begin
      m_st = 0; m_sel = 0; m_p = 0; m_o = 0; m_n = 0; m_fc = 0;
      m_addr = 0; m_cq = 0; m_vq = 0;
      return;
    end
    cr = left_click && !m_cq;
    ft = vblnk && !m_vq;
    case (m_sel)
      0: m_addr = start_addr;
      1: m_addr = shooter_addr;
      2: m_addr = keeper_addr;
      default: m_addr = end_addr;
    endcase
    if (ft) m_sel = m_st;
    nst = m_st;
    if (m_st == 0) begin
      if (cr) begin
        m_p = 0; m_o = 0; m_n = 0;
        nst = role_first ? 2 : 1;
      end
    end else if (m_st <= 2) begin
      if (result_valid) begin
        if (result_goal && m_st == 1) m_p = (m_p < 15) ? m_p + 1 : 15;
        if (result_goal && m_st == 2) m_o = (m_o < 15) ? m_o + 1 : 15;
        m_n++;
        if (m_n >= 2 * R && m_n % 2 == 0 && m_p != m_o)
          nst = (m_p > m_o) ? 3 : 4;
        else if (m_n == 30)
          nst = 4;
        else
          nst = 3 - m_st;
        m_fc = 0;
      end
    end else begin
      if (cr) nst = 0;
`ifdef AUTO_RESTART_EN
      else if (ft) begin
        m_fc++;
        if (m_fc == HOLD) nst = 0;
      end
`endif
    end
    m_st = nst;
    m_cq = left_click;
    m_vq = vblnk;
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    check("rom_addr", int'(rom_addr), int'(m_addr));
    check("screen_sel", int'(screen_sel), m_sel);
    check("player_score", int'(player_score), m_p);
    check("opp_score", int'(opp_score), m_o);
    check("shot_cnt", int'(shot_cnt), m_n);
  end

  task automatic cyc(int k = 1);
    repeat (k) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic click();
    left_click = 1; cyc();
    left_click = 0; cyc();
  endtask

  task automatic shot(bit g);
    result_valid = 1; result_goal = g; cyc();
    result_valid = 0; result_goal = 0; cyc(2);
  endtask

  initial begin
    rst = 1; left_click = 0; role_first = 0;
    result_valid = 0; result_goal = 0;
    start_addr = 20'h11111; shooter_addr = 20'h22222;
    keeper_addr = 20'h33333; end_addr = 20'h44444;
    @(negedge clk);
    cyc(3);
    rst = 0;
    check("rst_sel", int'(screen_sel), 0);
    check("rst_addr", int'(rom_addr), 0);
    cyc();
    result_valid = 1; result_goal = 1; cyc();
    result_valid = 0; result_goal = 0; cyc();
    check("start_ignore_rv", int'(player_score), 0);
    check("start_ignore_n", int'(shot_cnt), 0);

    left_click = 1; cyc(20);
    left_click = 0; cyc(15);
    check("to_shooter", int'(screen_sel), 1);
    check("shooter_addr", int'(rom_addr), 'h22222);

    for (int i = 0; i < 10; i++) shot(i < 5);
    cyc(15);
    check("win_sel", int'(screen_sel), 3);
    check("win_p", int'(player_score), 3);
    check("win_o", int'(opp_score), 2);
    check("win_n", int'(shot_cnt), 10);
    check("end_addr", int'(rom_addr), 'h44444);

    click(); click();
    for (int i = 0; i < 12; i++) shot(i < 11);
    cyc(15);
    check("sd_sel", int'(screen_sel), 3);
    check("sd_p", int'(player_score), 6);
    check("sd_o", int'(opp_score), 5);
    check("sd_n", int'(shot_cnt), 12);

    click(); click();
    for (int i = 0; i < 30; i++) shot(1);
    cyc(15);
    check("cap_sel", int'(screen_sel), 4);
    check("cap_n", int'(shot_cnt), 30);
    check("cap_p", int'(player_score), 15);
    cyc(120);
`ifdef AUTO_RESTART_EN
    check("auto_restart", int'(screen_sel), 0);
`else
    check("lose_hold", int'(screen_sel), 4);
`endif

    rst = 1; cyc(); rst = 0;
    role_first = 1;
    click(); cyc(15);
    check("to_keeper", int'(screen_sel), 2);
    shot(1);
    check("keeper_goal", int'(opp_score), 1);
    cyc(3);
    rst = 1; cyc(); rst = 0;
    check("mid_rst_sel", int'(screen_sel), 0);
    check("mid_rst_o", int'(opp_score), 0);
    check("mid_rst_addr", int'(rom_addr), 0);

    for (int i = 0; i < 4000; i++) begin
      start_addr   = 20'($urandom);
      shooter_addr = 20'($urandom);
      keeper_addr  = 20'($urandom);
      end_addr     = 20'($urandom);
      if ($urandom_range(0, 9) == 0) left_click = ~left_click;
      role_first   = 1'($urandom);
      result_valid = ($urandom_range(0, 3) == 0);
      result_goal  = 1'($urandom);
      rst          = ($urandom_range(0, 999) == 0);
      cyc();
    end
    rst = 0; result_valid = 0;
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_screen_ctl.md
# game_screen_ctl

Top-level game sequencer for the penalty simulator. It runs the match state machine (start → alternating shooter/keeper rounds → win/lose) and keeps the score. It selects which screen module drives the VGA output, and arbitrates the shared background-image ROM address between the start, shooter, keeper and end screens. Screen switches are frame-aligned so a screen change never tears mid-frame.

## Interface
Parameters:
- ROUNDS, 5, regulation shots per side (shot pairs before a result is decided)
- END_HOLD_FRAMES, 180, frames the WIN/LOSE screen is held before auto-restart (only with AUTO_RESTART_EN)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- vblnk  in  1  vertical blank from VGA timing; its rising edge marks the frame boundary
- left_click  in  1  debounced mouse button level
- role_first  in  1  player role in the first round: 0 = shooter, 1 = keeper
- result_valid  in  1  one-cycle pulse: current shot finished
- result_goal  in  1  qualifies result_valid: 1 = goal scored, 0 = saved/missed
- start_addr, shooter_addr, keeper_addr, end_addr  in  20 each  ROM address requests from each screen
- rom_addr  out  20  address driven to the shared image ROM
- screen_sel  out  3  active screen: 0 START, 1 SHOOTER, 2 KEEPER, 3 WIN, 4 LOSE
- player_score  out  4  player goals
- opp_score  out  4  opponent goals
- shot_cnt  out  5  completed shots in the current match

## Operation
- Internal state `state` uses the screen_sel encoding. It updates on events. screen_sel follows `state` only at frame boundaries.
- Click edge: click_q <= left_click; click_rise = left_click & ~click_q.
- START: on click_rise, clear scores and shot_cnt. Go to SHOOTER if role_first = 0, else KEEPER.
- SHOOTER/KEEPER: on result_valid with result_goal = 1:
  - In SHOOTER, player_score increments.
  - In KEEPER, opp_score increments.
  - Both scores saturate at 15.
- On every result_valid, shot_cnt increments. Let n be the new value. The next state is:
  - n ≥ 2·ROUNDS, n even, scores differ → WIN if player_score > opp_score, else LOSE.
  - n = 30 with scores tied → LOSE (sudden-death cap).
  - Otherwise → the other of SHOOTER/KEEPER (roles alternate every shot).
- Clicks are ignored in SHOOTER/KEEPER.
- WIN/LOSE: click_rise → START. Scores and shot_cnt are held for display until the next match starts.
- result_valid is ignored in START, WIN and LOSE.
- Simultaneous click_rise and result_valid: only the event valid for the current state is acted on.

## Timing
- Reset values: rom_addr = 0, screen_sel = 0 (START), player_score = 0, opp_score = 0, shot_cnt = 0, state = START, click_q = 0, frame counter = 0.
- Reset takes effect on the next clk edge regardless of frame position. screen_sel = START immediately after reset.
- Frame boundary: vblnk_q registered; frame_tick = vblnk & ~vblnk_q.
- screen_sel <= state in the cycle after frame_tick. A state change is visible on screen_sel 1 to (frame + 1) cycles after its event.
- If state changes twice within one frame, only the value present at frame_tick is shown.
- rom_addr <= address input selected by the current screen_sel (WIN and LOSE both select end_addr). Latency is 1 clk.
- Scores and shot_cnt update 1 clk after result_valid. State updates in the same cycle.

## Configuration
- AUTO_RESTART_EN defined: an 8-bit frame counter clears on entry to WIN/LOSE and increments on each frame_tick. When it reaches END_HOLD_FRAMES, state → START. click_rise still exits early.
- AUTO_RESTART_EN undefined: WIN/LOSE are left only by click_rise. No frame counter is synthesised.

## Test plan
- Reset mid-frame with state = KEEPER → next cycle screen_sel = 0, all scores 0, rom_addr = 0.
- START, role_first = 0, click rise → state SHOOTER. screen_sel stays 0 until the cycle after the next vblnk rise, then becomes 1. rom_addr tracks shooter_addr one cycle later.
- Ten shots alternating, with results giving player 3 : opp 2 → after the 10th result_valid, state = WIN, shot_cnt = 10, screen_sel = 3 after the next frame tick. rom_addr = end_addr.
- Tie 5:5 after 10 shots → play continues. Shots 11 (goal) and 12 (save) give 6:5 → WIN. A forced tie through shot 30 → LOSE.
- Click held high across the START → SHOOTER transition: no further transition. result_valid in START: scores unchanged.
- With AUTO_RESTART_EN and END_HOLD_FRAMES = 3: LOSE returns to START after 3 frame ticks. Without the macro, LOSE holds for 10 frames until a click.
